// File: rtl/qproc_time_ctrl_gen.sv
`default_nettype none
// ============================================================================
//  Module   : qproc_time_ctrl_gen
//  Purpose  : Time-base controller for the processor timing domain. Builds
//             the absolute time counter and the initial-offset register from
//             quasi-static control-domain requests (reset, init, run, signed
//             offset update), and provides an armable time alarm.
//  Revision : 1.0 - initial release
// ============================================================================
module qproc_time_ctrl_gen #(
  parameter int TIME_W  = 48,
  parameter int DT_W    = 32,
  parameter int SYNC_ST = 2
) (
  input  logic              t_clk_i,
  input  logic              t_rst_i,
  input  logic              c_time_rst_i,
  input  logic              c_time_init_i,
  input  logic              c_time_en_i,
  input  logic              c_time_updt_i,
  input  logic              c_updt_sub_i,
  input  logic [DT_W-1:0]   c_offset_dt_i,
  input  logic [TIME_W-1:0] c_alarm_val_i,
  input  logic              c_alarm_arm_i,
  output logic              t_time_en_o,
  output logic [TIME_W-1:0] t_time_abs_o,
  output logic [TIME_W-1:0] t_init_off_o,
  output logic              t_alarm_o,
  output logic              t_armed_o
);

  localparam int C_NCTL = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_INIT   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_RUN    = 3'd4,
    ST_UPDATE = 3'd5
  } state_t;

  // Control synchroniser: bit 0 rst, 1 init, 2 en, 3 updt, 4 arm
  logic [SYNC_ST-1:0][C_NCTL-1:0] r_sync;
  logic                           r_updt_d;
  logic                           r_arm_d;
  state_t                         r_state;
  logic [TIME_W-1:0]              r_time;
  logic [TIME_W-1:0]              r_off;
  logic                           r_armed;
  logic                           r_alarm;

  logic              w_s_rst, w_s_init, w_s_en, w_s_updt, w_s_arm;
  logic              w_updt_edge, w_arm_edge;
  logic [TIME_W-1:0] w_dt_ext, w_upd_dt, w_alarm_diff;
  logic [TIME_W-1:0] w_time_nxt, w_off_nxt;
  state_t            w_state_nxt;
  logic              w_fire, w_enter_clr;

  assign w_s_rst     = r_sync[SYNC_ST-1][0];
  assign w_s_init    = r_sync[SYNC_ST-1][1];
  assign w_s_en      = r_sync[SYNC_ST-1][2];
  assign w_s_updt    = r_sync[SYNC_ST-1][3];
  assign w_s_arm     = r_sync[SYNC_ST-1][4];
  assign w_updt_edge = w_s_updt & ~r_updt_d;
  assign w_arm_edge  = w_s_arm & ~r_arm_d;

  // Zero-extended delta; subtraction is done by adding the two's complement
  assign w_dt_ext = TIME_W'(c_offset_dt_i);
  assign w_upd_dt = c_updt_sub_i ? (~w_dt_ext + TIME_W'(1)) : w_dt_ext;

  // Signed >= compare via the difference MSB, tolerant of wrap within half range
  assign w_alarm_diff = r_time - c_alarm_val_i;
  assign w_fire       = r_armed & ~w_alarm_diff[TIME_W-1];
  assign w_enter_clr  = ((w_state_nxt == ST_RESET) || (w_state_nxt == ST_INIT)) &&
                        (w_state_nxt != r_state);

  // Shift the control levels through the synchroniser and keep edge history
  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      r_sync   <= '0;
      r_updt_d <= 1'b0;
      r_arm_d  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_ST-2:0],
                   {c_alarm_arm_i, c_time_updt_i, c_time_en_i, c_time_init_i, c_time_rst_i}};
      r_updt_d <= w_s_updt;
      r_arm_d  <= w_s_arm;
    end
  end

  // Next-state, next-time and next-offset selection
  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_off_nxt   = r_off;
    case (r_state)
      ST_IDLE: begin
        if (w_s_rst)          w_state_nxt = ST_RESET;
        else if (w_s_init)    w_state_nxt = ST_INIT;
        else if (w_s_en)      w_state_nxt = ST_RUN;
        else if (w_updt_edge) w_state_nxt = ST_UPDATE;
      end
      ST_RESET: begin
        w_time_nxt = '0;
        if (!w_s_rst) w_state_nxt = ST_IDLE;
      end
      ST_INIT: begin
        w_time_nxt = '0;
        w_off_nxt  = w_dt_ext;
        if (!w_s_init) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_time_nxt  = r_off;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_time_nxt = r_time + TIME_W'(1);
        if (w_s_rst)          w_state_nxt = ST_RESET;
        else if (w_s_init)    w_state_nxt = ST_INIT;
        else if (w_updt_edge) w_state_nxt = ST_UPDATE;
        else if (!w_s_en)     w_state_nxt = ST_IDLE;
      end
      ST_UPDATE: begin
        // Always returns to RUN; RUN drops to IDLE next cycle if disabled
        w_time_nxt  = r_time + TIME_W'(1) + w_upd_dt;
        w_off_nxt   = r_off + w_upd_dt;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // LOAD and UPDATE always complete before a reset/init takes hold
    if ((w_s_rst || w_s_init) && (r_state != ST_LOAD) && (r_state != ST_UPDATE))
      w_time_nxt = '0;
  end

  // State, time and offset registers
  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      r_state <= ST_IDLE;
      r_time  <= '0;
      r_off   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_time  <= w_time_nxt;
      r_off   <= w_off_nxt;
    end
  end

  // Alarm: entering RESET/INIT silently disarms, a fire beats a new arm edge
  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      r_armed <= 1'b0;
      r_alarm <= 1'b0;
    end else if (w_enter_clr) begin
      r_armed <= 1'b0;
      r_alarm <= 1'b0;
    end else if (w_fire) begin
      r_armed <= 1'b0;
      r_alarm <= 1'b1;
    end else begin
      r_alarm <= 1'b0;
      if (w_arm_edge) r_armed <= 1'b1;
    end
  end

  assign t_time_en_o  = w_s_en;
  assign t_time_abs_o = r_time;
  assign t_init_off_o = r_off;
  assign t_alarm_o    = r_alarm;
  assign t_armed_o    = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_qproc_time_ctrl_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qproc_time_ctrl_gen
//  Purpose  : Directed self-checking bench for qproc_time_ctrl_gen, built
//             with a 16-bit time base so wrap-around is reachable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qproc_time_ctrl_gen;

  localparam int TIME_W  = 16;
  localparam int DT_W    = 16;
  localparam int SYNC_ST = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              c_time_rst = 1'b0, c_time_init = 1'b0, c_time_en = 1'b0;
  logic              c_time_updt = 1'b0, c_updt_sub = 1'b0, c_alarm_arm = 1'b0;
  logic [DT_W-1:0]   c_offset_dt = '0;
  logic [TIME_W-1:0] c_alarm_val = '0;
  logic              t_time_en, t_alarm, t_armed;
  logic [TIME_W-1:0] t_time_abs, t_init_off;

  int n_vec = 0;
  int n_err = 0;

  qproc_time_ctrl_gen #(.TIME_W(TIME_W), .DT_W(DT_W), .SYNC_ST(SYNC_ST)) u_dut (
    .t_clk_i       (clk),
    .t_rst_i       (rst),
    .c_time_rst_i  (c_time_rst),
    .c_time_init_i (c_time_init),
    .c_time_en_i   (c_time_en),
    .c_time_updt_i (c_time_updt),
    .c_updt_sub_i  (c_updt_sub),
    .c_offset_dt_i (c_offset_dt),
    .c_alarm_val_i (c_alarm_val),
    .c_alarm_arm_i (c_alarm_arm),
    .t_time_en_o   (t_time_en),
    .t_time_abs_o  (t_time_abs),
    .t_init_off_o  (t_init_off),
    .t_alarm_o     (t_alarm),
    .t_armed_o     (t_armed)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; sample and drive 1 ns after the edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    {c_time_rst, c_time_init, c_time_en, c_time_updt, c_updt_sub, c_alarm_arm} = '0;
    c_offset_dt = '0;
    c_alarm_val = '0;
    tick(3);
    rst = 1'b0;
  endtask

  // Init with offset dt, then run; returns one cycle after LOAD (time = dt+1)
  task automatic start_init(input logic [DT_W-1:0] dt);
    c_offset_dt = dt;
    c_time_init = 1'b1;
    c_time_en   = 1'b1;
    tick(4);
    c_time_init = 1'b0;
    tick(5);
  endtask

  task automatic test_reset();
    hard_reset();
    n_vec++;
    if ({t_time_en, t_alarm, t_armed, t_time_abs, t_init_off} !== '0) begin
      n_err++;
      $display("FAIL reset_state got en=%b al=%b arm=%b t=%h off=%h want all 0",
               t_time_en, t_alarm, t_armed, t_time_abs, t_init_off);
    end
  endtask

  task automatic test_run();
    hard_reset();
    c_time_en = 1'b1;
    tick(1);
    n_vec++;
    if (t_time_en !== 1'b0) begin n_err++; $display("FAIL run_en_early got %b want 0", t_time_en); end
    tick(1);
    n_vec++;
    if (t_time_en !== 1'b1) begin n_err++; $display("FAIL run_en_sync got %b want 1", t_time_en); end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd0) begin n_err++; $display("FAIL run_t0 got %0d want 0", t_time_abs); end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd1) begin n_err++; $display("FAIL run_first_inc got %0d want 1", t_time_abs); end
    tick(2);
    n_vec++;
    if (t_time_abs !== 16'd3) begin n_err++; $display("FAIL run_count got %0d want 3", t_time_abs); end
    c_time_en = 1'b0;
    tick(6);
    n_vec++;
    if (t_time_abs !== 16'd6 || t_time_en !== 1'b0) begin
      n_err++;
      $display("FAIL run_hold got t=%0d en=%b want t=6 en=0", t_time_abs, t_time_en);
    end
  endtask

  task automatic test_init();
    hard_reset();
    c_offset_dt = 16'd1000;
    c_time_init = 1'b1;
    c_time_en   = 1'b1;
    tick(4);
    n_vec++;
    if (t_time_abs !== 16'd0 || t_init_off !== 16'd1000) begin
      n_err++;
      $display("FAIL init_capture got t=%0d off=%0d want t=0 off=1000", t_time_abs, t_init_off);
    end
    c_time_init = 1'b0;
    tick(3);
    n_vec++;
    if (t_time_abs !== 16'd0) begin n_err++; $display("FAIL init_zero got %0d want 0", t_time_abs); end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd1000) begin n_err++; $display("FAIL init_load got %0d want 1000", t_time_abs); end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd1001 || t_time_en !== 1'b1) begin
      n_err++;
      $display("FAIL init_run got t=%0d en=%b want t=1001 en=1", t_time_abs, t_time_en);
    end
  endtask

  // Continues from test_init: running with time 1001, offset 1000
  task automatic test_update();
    c_offset_dt = 16'd50;
    c_updt_sub  = 1'b0;
    c_time_updt = 1'b1;
    tick(3);
    n_vec++;
    if (t_time_abs !== 16'd1004) begin n_err++; $display("FAIL upd_add_pre got %0d want 1004", t_time_abs); end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd1055 || t_init_off !== 16'd1050) begin
      n_err++;
      $display("FAIL upd_add got t=%0d off=%0d want t=1055 off=1050", t_time_abs, t_init_off);
    end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd1056) begin n_err++; $display("FAIL upd_add_post got %0d want 1056", t_time_abs); end
    c_time_updt = 1'b0;
    c_updt_sub  = 1'b1;
    c_offset_dt = 16'd20;
    tick(3);
    c_time_updt = 1'b1;
    tick(3);
    n_vec++;
    if (t_time_abs !== 16'd1062) begin n_err++; $display("FAIL upd_sub_pre got %0d want 1062", t_time_abs); end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd1043 || t_init_off !== 16'd1030) begin
      n_err++;
      $display("FAIL upd_sub got t=%0d off=%0d want t=1043 off=1030", t_time_abs, t_init_off);
    end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd1044) begin n_err++; $display("FAIL upd_sub_post got %0d want 1044", t_time_abs); end
    c_time_updt = 1'b0;
    c_updt_sub  = 1'b0;
  endtask

  task automatic test_wrap_alarm();
    int pulses;
    hard_reset();
    c_alarm_val = 16'h0002;
    start_init(16'hFFF7);
    c_alarm_arm = 1'b1;
    tick(3);
    n_vec++;
    if (t_armed !== 1'b1 || t_time_abs !== 16'hFFFB) begin
      n_err++;
      $display("FAIL wrap_armed got arm=%b t=%h want arm=1 t=fffb", t_armed, t_time_abs);
    end
    c_offset_dt = 16'd5;
    c_time_updt = 1'b1;
    tick(3);
    n_vec++;
    if (t_time_abs !== 16'hFFFE || t_alarm !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_pre got t=%h al=%b want t=fffe al=0", t_time_abs, t_alarm);
    end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'h0004 || t_init_off !== 16'hFFFC || t_alarm !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_jump got t=%h off=%h al=%b want t=0004 off=fffc al=0",
               t_time_abs, t_init_off, t_alarm);
    end
    tick(1);
    n_vec++;
    if (t_alarm !== 1'b1 || t_armed !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_fire got al=%b arm=%b want al=1 arm=0", t_alarm, t_armed);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (t_alarm === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin n_err++; $display("FAIL wrap_single got %0d extra pulses want 0", pulses); end
    c_time_updt = 1'b0;
    c_alarm_arm = 1'b0;
  endtask

  task automatic test_alarm_jump();
    hard_reset();
    c_alarm_val = 16'd500;
    start_init(16'd96);
    c_alarm_arm = 1'b1;
    tick(3);
    n_vec++;
    if (t_armed !== 1'b1 || t_time_abs !== 16'd100) begin
      n_err++;
      $display("FAIL alm_arm got arm=%b t=%0d want arm=1 t=100", t_armed, t_time_abs);
    end
    c_offset_dt = 16'd1000;
    c_time_updt = 1'b1;
    tick(4);
    n_vec++;
    if (t_time_abs !== 16'd1104 || t_alarm !== 1'b0 || t_armed !== 1'b1) begin
      n_err++;
      $display("FAIL alm_jump got t=%0d al=%b arm=%b want t=1104 al=0 arm=1",
               t_time_abs, t_alarm, t_armed);
    end
    tick(1);
    n_vec++;
    if (t_alarm !== 1'b1 || t_armed !== 1'b0) begin
      n_err++;
      $display("FAIL alm_fire got al=%b arm=%b want al=1 arm=0", t_alarm, t_armed);
    end
    c_alarm_arm = 1'b0;
    c_time_updt = 1'b0;
    c_alarm_val = 16'd20000;
    tick(1);
    n_vec++;
    if (t_alarm !== 1'b0) begin n_err++; $display("FAIL alm_pulse_len got %b want 0", t_alarm); end
    tick(2);
    c_alarm_arm = 1'b1;
    tick(3);
    n_vec++;
    if (t_armed !== 1'b1) begin n_err++; $display("FAIL alm_rearm got %b want 1", t_armed); end
    c_time_rst = 1'b1;
    tick(3);
    n_vec++;
    if (t_armed !== 1'b0 || t_alarm !== 1'b0 || t_time_abs !== 16'd0) begin
      n_err++;
      $display("FAIL alm_rst_clr got arm=%b al=%b t=%0d want arm=0 al=0 t=0",
               t_armed, t_alarm, t_time_abs);
    end
    tick(1);
    n_vec++;
    if (t_alarm !== 1'b0 || t_time_abs !== 16'd0 || t_init_off !== 16'd1096) begin
      n_err++;
      $display("FAIL alm_rst_hold got al=%b t=%0d off=%0d want al=0 t=0 off=1096",
               t_alarm, t_time_abs, t_init_off);
    end
    c_time_rst  = 1'b0;
    c_alarm_arm = 1'b0;
  endtask

  task automatic test_async_rst();
    hard_reset();
    start_init(16'd1000);
    c_offset_dt = 16'd7;
    c_time_updt = 1'b1;
    tick(3);
    // DUT is in UPDATE now; abort it asynchronously
    rst = 1'b1;
    #1;
    n_vec++;
    if ({t_time_en, t_alarm, t_armed, t_time_abs, t_init_off} !== '0) begin
      n_err++;
      $display("FAIL arst_clear got en=%b t=%0d off=%0d want all 0", t_time_en, t_time_abs, t_init_off);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    n_vec++;
    if (t_time_en !== 1'b0 || t_time_abs !== 16'd0) begin
      n_err++;
      $display("FAIL arst_resync got en=%b t=%0d want en=0 t=0", t_time_en, t_time_abs);
    end
    tick(2);
    n_vec++;
    if (t_time_en !== 1'b1 || t_time_abs !== 16'd0) begin
      n_err++;
      $display("FAIL arst_hold got en=%b t=%0d want en=1 t=0", t_time_en, t_time_abs);
    end
    tick(1);
    n_vec++;
    if (t_time_abs !== 16'd1 || t_init_off !== 16'd0) begin
      n_err++;
      $display("FAIL arst_run got t=%0d off=%0d want t=1 off=0", t_time_abs, t_init_off);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_init();
    test_update();
    test_wrap_alarm();
    test_alarm_jump();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qproc_time_ctrl_gen.md
# qproc_time_ctrl_gen

Parametrised time-base controller for the QICK processor timing domain. It generates the absolute time counter and the initial-offset register from quasi-static control-domain requests: reset, init, run, and offset update. It extends the fixed 48/32-bit controller with configurable widths and synchroniser depth, signed (add/subtract) offset updates, and an armable time alarm. It sits between the control-domain register bank and the timed-instruction FIFOs and dispatchers.

## Interface
- TIME_W, 48, width of absolute time and offset (16..64)
- DT_W, 32, width of update/offset delta (DT_W ≤ TIME_W)
- SYNC_ST, 2, synchroniser flop stages on each control input (≥2)

- t_clk_i  in  1  time-domain clock
- t_rst_i  in  1  asynchronous active-high reset
- c_time_rst_i  in  1  level: force time to 0
- c_time_init_i  in  1  level: capture offset, then load it into time
- c_time_en_i  in  1  level: time runs
- c_time_updt_i  in  1  level; rising edge requests an offset update
- c_updt_sub_i  in  1  update direction: 0 adds delta, 1 subtracts delta
- c_offset_dt_i  in  DT_W  delta / initial offset, quasi-static
- c_alarm_val_i  in  TIME_W  alarm time, quasi-static
- c_alarm_arm_i  in  1  level; rising edge arms the alarm
- t_time_en_o  out  1  synchronised c_time_en_i, used as the FIFO enable
- t_time_abs_o  out  TIME_W  absolute time
- t_init_off_o  out  TIME_W  accumulated offset
- t_alarm_o  out  1  one-cycle pulse when the alarm fires
- t_armed_o  out  1  alarm armed

## Operation
- Each c_* level passes through SYNC_ST flops (reset value 0) to give s_rst, s_init, s_en, s_updt, s_arm.
- updt_edge = s_updt & ~s_updt_d. arm_edge is formed the same way.
- Data inputs c_offset_dt_i, c_updt_sub_i and c_alarm_val_i are sampled directly. They must be stable from SYNC_ST+1 cycles before the control edge until the operation completes.
- dt_ext is c_offset_dt_i zero-extended to TIME_W. All arithmetic is modulo 2^TIME_W.
- FSM states are IDLE, RESET, INIT, LOAD, RUN, UPDATE. The reset state is IDLE.
  - IDLE: time holds. Priority: s_rst→RESET, s_init→INIT, s_en→RUN, updt_edge→UPDATE.
  - RESET: time <= 0. Go to IDLE when ~s_rst. The offset is unchanged.
  - INIT: time <= 0, offset <= dt_ext every cycle. Go to LOAD when ~s_init.
  - LOAD: time <= offset. Go to RUN.
  - RUN: time <= time+1. Priority: s_rst→RESET, s_init→INIT, updt_edge→UPDATE, ~s_en→IDLE.
  - UPDATE: time <= time+1±dt_ext and offset <= offset±dt_ext (sign from c_updt_sub_i). Go to RUN unconditionally, even if ~s_en; RUN then exits to IDLE next cycle.
- s_rst or s_init high in any state forces time <= 0 on that cycle, except in LOAD and UPDATE, which complete first.
- Alarm behaviour:
  - arm_edge sets armed.
  - While armed, when the MSB of (time_abs − c_alarm_val_i) is 0, the block pulses t_alarm_o and clears armed. This is a signed ≥ compare that is tolerant of jumps and wrap within half range.
  - Entering RESET or INIT clears armed without a pulse.
  - If arm_edge and fire coincide, fire wins and armed ends 0.

## Timing
- Reset values: all outputs 0, offset 0, FSM IDLE, synchronisers 0.
- Control latency: a c_* change is visible as s_* after SYNC_ST edges. The FSM reacts on the next edge.
- From c_time_en_i rising to the first increment of t_time_abs_o: SYNC_ST+2 cycles.
- Time, offset and armed are registered. Outputs come straight from the registers with no combinational path from inputs.
- The alarm compare uses registered time_abs. t_alarm_o is asserted in the cycle after time_abs first satisfies the compare.
- Asynchronous reset mid-operation returns to reset values immediately. Any in-flight update is lost.
- A back-to-back update edge needs s_updt low for ≥1 cycle. UPDATE occupies one cycle, so an edge arriving while in UPDATE is taken from RUN.
- Updates issued while in RESET or INIT are dropped.

## Test plan
- Reset, then c_time_en_i=1 → t_time_en_o rises after SYNC_ST cycles. Time counts 0,1,2… starting SYNC_ST+2 cycles after the input edge. Drop en → time holds.
- c_offset_dt_i=1000, pulse c_time_init_i, en=1 → t_init_off_o=1000. Time is 0 during init, then 1000, 1001… after LOAD.
- Running at T, update add dt=50 → time jumps to T+51 in one cycle and offset +50. Repeat with c_updt_sub_i=1, dt=20 → time T'+1−20, offset −20.
- TIME_W=16, time near 0xFFFE, add dt=5 → wraps to 0x0004 modulo. Alarm at 0x0002, armed before the wrap, fires exactly once.
- Arm alarm=500 while at 100, then update +1000 → single t_alarm_o pulse after the jump and armed=0. Re-arm then assert c_time_rst_i → armed cleared, no pulse.
- Assert t_rst_i during UPDATE → all outputs 0 immediately. After release, time stays 0 until en resynchronises.
